// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mux_scan_ctrl
// Purpose : Sequences an analog mux across a channel range, settles, triggers
//           the ADC and emits one tagged sample per channel.
// Rev     : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int ADC_TIMEOUT = 1024,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [5:0]        first_ch,
    input  logic [5:0]        last_ch,
    input  logic [15:0]       settle_cyc,
    output logic [5:0]        addr,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              smp_valid,
    output logic [5:0]        smp_ch,
    output logic [DATA_W-1:0] smp_data,
    output logic              busy,
    output logic              scan_done,
    output logic              err_timeout
);

    localparam int              c_TW   = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(ADC_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETTLE = 3'd1;
    localparam logic [2:0] c_TRIG   = 3'd2;
    localparam logic [2:0] c_WAIT   = 3'd3;
    localparam logic [2:0] c_STORE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [5:0]        r_addr;
    logic [5:0]        r_first;
    logic [5:0]        r_last;
    logic [15:0]       r_settle;
    logic              r_cont;
    logic [15:0]       r_scnt;
    logic [c_TW-1:0]   r_wcnt;
    logic              r_captured;
    logic [5:0]        r_smp_ch;
    logic [DATA_W-1:0] r_smp_data;
    logic              r_err;

    logic w_accept;
    logic w_capture;
    logic w_timeout;
    logic w_abort;
    logic w_last;

    assign w_abort = stop && (r_state != c_IDLE);
    assign w_last  = (r_addr == r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        if (w_abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && !stop) begin
                        w_accept    = 1'b1;
                        w_state_nxt = c_SETTLE;
                    end
                end
                c_SETTLE: begin
                    if (r_scnt == r_settle) begin
                        w_state_nxt = c_TRIG;
                    end
                end
                c_TRIG: begin
                    w_state_nxt = c_WAIT;
                end
                c_WAIT: begin
                    // a conversion landing in the expiry cycle still counts
                    if (adc_done) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_STORE;
                    end else if (r_wcnt == c_TMAX) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = c_STORE;
                    end
                end
                c_STORE: begin
                    if (!w_last || r_cont) begin
                        w_state_nxt = c_SETTLE;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_settle   <= '0;
            r_cont     <= 1'b0;
            r_scnt     <= '0;
            r_wcnt     <= '0;
            r_captured <= 1'b0;
            r_smp_ch   <= '0;
            r_smp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_first  <= first_ch;
                r_last   <= last_ch;
                r_settle <= settle_cyc;
                r_cont   <= continuous;
                r_addr   <= first_ch;
                r_err    <= 1'b0;
                r_scnt   <= '0;
            end
            // an abort freezes the datapath, addr included
            if (!w_abort) begin
                case (r_state)
                    c_SETTLE: r_scnt <= r_scnt + 16'd1;
                    c_TRIG:   r_wcnt <= '0;
                    c_WAIT: begin
                        r_wcnt <= r_wcnt + c_TW'(1);
                        if (w_capture) begin
                            r_smp_data <= adc_data;
                            r_smp_ch   <= r_addr;
                            r_captured <= 1'b1;
                        end else if (w_timeout) begin
                            r_err      <= 1'b1;
                            r_captured <= 1'b0;
                        end
                    end
                    c_STORE: begin
                        r_scnt <= '0;
                        if (!w_last) begin
                            r_addr <= r_addr + 6'd1;
                        end else if (r_cont) begin
                            r_addr <= r_first;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign addr        = r_addr;
    assign adc_start   = (r_state == c_TRIG);
    assign smp_valid   = (r_state == c_STORE) && r_captured && !stop;
    assign scan_done   = (r_state == c_STORE) && w_last && !stop;
    assign busy        = (r_state != c_IDLE);
    assign smp_ch      = r_smp_ch;
    assign smp_data    = r_smp_data;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_scan_ctrl
// Purpose : Table-driven bench; a timeline model predicts every output cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int T = 16;
    localparam int N = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, continuous, adc_done;
    logic [5:0]  first_ch, last_ch;
    logic [15:0] settle_cyc;
    logic [11:0] adc_data;
    logic [5:0]  addr, smp_ch;
    logic [11:0] smp_data;
    logic        adc_start, smp_valid, busy, scan_done, err_timeout;

    mux_scan_ctrl #(.ADC_TIMEOUT(T), .DATA_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .first_ch(first_ch), .last_ch(last_ch), .settle_cyc(settle_cyc),
        .addr(addr), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data), .busy(busy),
        .scan_done(scan_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // per-cycle stimulus (d_*) and expected outputs (e_*)
    bit          d_start[N], d_stop[N], d_cont[N], d_done[N];
    logic [5:0]  d_first[N], d_last[N];
    logic [15:0] d_settle[N];
    logic [11:0] d_data[N];
    bit          e_adc_start[N], e_valid[N], e_scan_done[N], e_busy[N], e_err[N];
    logic [5:0]  e_ch[N];
    logic [11:0] e_data[N];

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void wipe(input int c0);
        for (int c = c0; c < N; c++) begin
            d_start[c] = 1'b0;        d_stop[c]  = ($urandom % 4 == 0);
            d_cont[c]  = $urandom % 2; d_first[c] = 6'($urandom);
            d_last[c]  = 6'($urandom); d_settle[c] = 16'($urandom);
            d_data[c]  = 12'($urandom); d_done[c] = ($urandom % 4 == 0);
            e_adc_start[c] = 1'b0; e_valid[c] = 1'b0; e_scan_done[c] = 1'b0;
            e_busy[c] = 1'b0; e_err[c] = 1'b0; e_ch[c] = '0; e_data[c] = '0;
        end
    endfunction

    // Timeline of one scan accepted in cycle a. Step k triggers in cycle t,
    // the ADC answers L cycles later; lat_fix > 0 forces L and data 0x100+ch.
    function automatic int plan(input int a, input int first, input int last,
                                input int settle, input bit cont,
                                input int stop_step, input int lat_fix);
        int t, st, k, ch, L, w, endc, nsteps;
        bit stopped;
        logic [11:0] val;
        d_start[a] = 1'b1; d_stop[a] = 1'b0; d_cont[a] = cont;
        d_first[a] = 6'(first); d_last[a] = 6'(last); d_settle[a] = 16'(settle);
        for (int c = a + 1; c < N; c++) e_err[c] = 1'b0;
        nsteps  = ((last - first) & 63) + 1;
        ch      = first;
        k       = 0;
        t       = a + settle + 2;
        endc    = a;
        stopped = 1'b0;
        while (k < 1000) begin
            e_adc_start[t] = 1'b1;
            e_ch[t]        = 6'(ch);
            L = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, T + 3));
            w = (L < T) ? L : T;
            for (int c = t + 1; c <= t + w; c++) d_done[c] = 1'b0;
            if (k == stop_step) begin
                endc    = t + 1 + int'($urandom_range(0, w - 1));
                stopped = 1'b1;
                if (L <= T && t + L == endc) d_done[endc] = 1'b1;
                break;
            end
            if (L <= T) begin
                val = (lat_fix > 0) ? 12'(12'h100 + ch) : 12'($urandom);
                d_done[t + L] = 1'b1; d_data[t + L] = val;
                st = t + L + 1;
                e_valid[st] = 1'b1; e_ch[st] = 6'(ch); e_data[st] = val;
            end else begin
                st = t + T + 1;
                for (int c = st; c < N; c++) e_err[c] = 1'b1;
            end
            if ((k % nsteps) == nsteps - 1) begin
                e_scan_done[st] = 1'b1;
                if (!cont) begin
                    endc = st;
                    break;
                end
                ch = first;
            end else begin
                ch = (ch + 1) & 63;
            end
            k++;
            t = st + settle + 2;
        end
        for (int c = a + 1; c <= endc; c++) begin
            e_busy[c]  = 1'b1;
            d_start[c] = $urandom % 2;
            d_stop[c]  = stopped && (c == endc);
        end
        return endc;
    endfunction

    task automatic drive(input int c);
        start = d_start[c]; stop = d_stop[c]; continuous = d_cont[c];
        first_ch = d_first[c]; last_ch = d_last[c]; settle_cyc = d_settle[c];
        adc_done = d_done[c]; adc_data = d_data[c];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(cyc);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("adc_start", adc_start, e_adc_start[cyc]);
            chk("smp_valid", smp_valid, e_valid[cyc]);
            chk("scan_done", scan_done, e_scan_done[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("err_timeout", err_timeout, e_err[cyc]);
            if (e_adc_start[cyc]) chk("addr", addr, e_ch[cyc]);
            if (e_valid[cyc]) begin
                chk("smp_ch", smp_ch, e_ch[cyc]);
                chk("smp_data", smp_data, e_data[cyc]);
            end
        end
    end

    initial begin
        #(N * 10);
        $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, N);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, endc, g, first, last, nsteps, sstep;
        bit cont;
        rst = 1'b1;
        wipe(0);
        drive(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", addr, 0);           chk("rst_busy", busy, 0);
        chk("rst_adc_start", adc_start, 0); chk("rst_smp_valid", smp_valid, 0);
        chk("rst_scan_done", scan_done, 0); chk("rst_err", err_timeout, 0);
        chk("rst_smp_ch", smp_ch, 0);       chk("rst_smp_data", smp_data, 0);
        drive(cyc);
        rst = 1'b0;
        model_on = 1'b1;

        // basic pass, with adc_done forced high through SETTLE
        a = cyc + 2;
        endc = plan(a, 2, 4, 3, 1'b0, -1, 5);
        for (int c = a + 1; c <= a + 4; c++) d_done[c] = 1'b1;
        chk("pin_trig_first", e_adc_start[a + 5], 1);
        chk("pin_valid_ch2", e_valid[a + 11], 1);
        chk("pin_data_ch2", e_data[a + 11], 'h102);
        chk("pin_ch3", e_ch[a + 22], 3);
        chk("pin_done_ch4", e_scan_done[a + 33], 1);
        chk("pin_busy_end", e_busy[a + 34], 0);
        run_to(endc + 2);
        chk("basic_last_data", smp_data, 'h104);
        chk("basic_last_ch", smp_ch, 4);

        // wrap 62 -> 1
        a = cyc + 1;
        endc = plan(a, 62, 1, 2, 1'b0, -1, 4);
        chk("pin_wrap_62", e_ch[a + 9], 62);
        chk("pin_wrap_0", e_ch[a + 27], 0);
        chk("pin_wrap_nodone", e_scan_done[a + 27], 0);
        chk("pin_wrap_done", e_scan_done[a + 36], 1);
        run_to(endc + 2);

        // ADC never answers on channel 5
        a = cyc + 1;
        endc = plan(a, 5, 5, 1, 1'b0, -1, 1000);
        chk("pin_to_err_before", e_err[a + 19], 0);
        chk("pin_to_err_set", e_err[a + 20], 1);
        chk("pin_to_done", e_scan_done[a + 20], 1);
        chk("pin_to_novalid", e_valid[a + 20], 0);
        run_to(endc + 2);
        chk("timeout_sticky", err_timeout, 1);

        // continuous, aborted in the second pass
        a = cyc + 1;
        endc = plan(a, 0, 1, 1, 1'b1, 3, 3);
        run_to(endc + 3);
        chk("err_cleared_by_start", err_timeout, 0);

        // settle=0, then start together with stop in IDLE
        a = cyc + 1;
        endc = plan(a, 7, 8, 0, 1'b0, -1, 2);
        chk("pin_settle0_trig", e_adc_start[a + 2], 1);
        g = endc + 2;
        d_start[g] = 1'b1; d_stop[g] = 1'b1;
        run_to(g + 2);
        chk("start_stop_ignored", busy, 0);

        // reset during SETTLE
        a = cyc + 1;
        endc = plan(a, 10, 12, 5, 1'b0, -1, 4);
        run_to(a + 2);
        model_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_smp_ch", smp_ch, 0);    chk("mid_rst_smp_data", smp_data, 0);
        chk("mid_rst_adc_start", adc_start, 0); chk("mid_rst_err", err_timeout, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_held_busy", busy, 0);
        wipe(cyc);
        drive(cyc);
        rst = 1'b0;
        model_on = 1'b1;
        a = cyc + 1;
        endc = plan(a, 3, 3, 2, 1'b0, -1, 4);
        run_to(endc + 2);

        // randomized scans
        repeat (40) begin
            if (cyc < N - 1500) begin
                a      = cyc + 1 + int'($urandom_range(0, 2));
                first  = int'($urandom_range(0, 63));
                last   = (first + int'($urandom_range(0, 5))) & 63;
                nsteps = ((last - first) & 63) + 1;
                cont   = ($urandom % 3 == 0);
                if (cont) sstep = int'($urandom_range(0, 2 * nsteps + 1));
                else      sstep = ($urandom % 4 == 0) ? int'($urandom_range(0, nsteps - 1)) : -1;
                endc = plan(a, first, last, int'($urandom_range(0, 6)), cont, sstep, 0);
                g = endc + 1;
                if ($urandom % 2 == 1) begin
                    d_start[g] = 1'b1; d_stop[g] = 1'b1;
                end
                run_to(endc + 1 + int'($urandom_range(0, 3)));
            end
        end
        run_to(cyc + 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
